// File: rtl/imm_extend_builder.sv
// Builds a DATA_W-bit immediate from FIELD_W-bit chunks (MS chunk first) and
// zero/sign-extends it onto a valid/ready output for the ALU B-operand mux.
module imm_extend_builder #(
  parameter int FIELD_W    = 2,
  parameter int DATA_W     = 8,
  parameter int MAX_CHUNKS = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FIELD_W-1:0] entrada,
  input  logic              in_last,
  input  logic              sign_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] saida,
  output logic [CNT_W-1:0]  chunk_count,
  output logic              overflow
);

  generate
    if (FIELD_W * MAX_CHUNKS > DATA_W) begin : g_bad_width
      $error("imm_extend_builder: FIELD_W*MAX_CHUNKS exceeds DATA_W");
    end
    if (MAX_CHUNKS >= (1 << CNT_W)) begin : g_bad_cnt
      $error("imm_extend_builder: CNT_W too narrow for MAX_CHUNKS");
    end
  endgenerate

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] new_acc;
  logic [CNT_W-1:0]  new_cnt;
  logic [DATA_W-1:0] ext_val;
  logic              sign_bit;
  logic              closing;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);

  // Next accumulator/count for an accepted beat, plus the extended word it
  // would produce if this beat closes the word. Bits above n*FIELD_W are
  // filled with the sign bit or zero; when n*FIELD_W == DATA_W nothing is filled.
  always_comb begin
    int nbits;
    new_acc  = (acc << FIELD_W) | DATA_W'(entrada);
    new_cnt  = chunk_count + CNT_W'(1);
    closing  = in_last || (new_cnt == CNT_W'(MAX_CHUNKS));
    nbits    = int'(new_cnt) * FIELD_W;
    sign_bit = 1'b0;
    ext_val  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == nbits - 1) sign_bit = new_acc[i];
    end
    for (int i = 0; i < DATA_W; i++) begin
      if (i < nbits) ext_val[i] = new_acc[i];
      else           ext_val[i] = sign_mode & sign_bit;
    end
  end

  // clear outranks both handshakes; saida survives clear and handshake so the
  // B-operand mux never sees a glitch to zero between words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      saida       <= '0;
      chunk_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      acc         <= '0;
      chunk_count <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_valid) begin
            acc         <= new_acc;
            chunk_count <= new_cnt;
            if (closing) begin
              state    <= HOLD;
              saida    <= ext_val;
              overflow <= ~in_last;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state       <= IDLE;
            acc         <= '0;
            chunk_count <= '0;
            overflow    <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          acc         <= '0;
          chunk_count <= '0;
          overflow    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_builder.sv
// Directed self-checking bench for imm_extend_builder at default parameters
// (FIELD_W=2, DATA_W=8, MAX_CHUNKS=4).
module tb_imm_extend_builder;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] entrada;
  logic       in_last;
  logic       sign_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] saida;
  logic [2:0] chunk_count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  imm_extend_builder dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .entrada     (entrada),
    .in_last     (in_last),
    .sign_mode   (sign_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .saida       (saida),
    .chunk_count (chunk_count),
    .overflow    (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One accepted-beat attempt: inputs held across one rising edge.
  task automatic applyStimulus(input logic [1:0] data, input logic last,
                               input logic sm);
    in_valid  = 1'b1;
    entrada   = data;
    in_last   = last;
    sign_mode = sm;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    sign_mode = 1'b0;
  endtask

  task automatic checkWord(input string tag, input logic [7:0] exp_saida,
                           input logic [2:0] exp_cnt, input logic exp_ovf);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".saida"}, 32'(saida), 32'(exp_saida));
    checkOutput({tag, ".count"}, 32'(chunk_count), 32'(exp_cnt));
    checkOutput({tag, ".ovf"},   32'(overflow), 32'(exp_ovf));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; entrada = 2'b00;
    in_last = 1'b0; sign_mode = 1'b0; out_ready = 1'b0;
    #3;
    checkOutput("rst.valid", 32'(out_valid), 32'd0);
    checkOutput("rst.saida", 32'(saida), 32'd0);
    checkOutput("rst.count", 32'(chunk_count), 32'd0);
    checkOutput("rst.ovf",   32'(overflow), 32'd0);
    #9 reset = 1'b0;
    #1 checkOutput("rst.ready", 32'(in_ready), 32'd1);

    // Single-beat words, legacy 2->8 behaviour and sign extension
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkWord("s1a", 8'h03, 3'd1, 1'b0);
    handshake();
    checkOutput("s1a.drop", 32'(out_valid), 32'd0);
    applyStimulus(2'b10, 1'b1, 1'b1);
    checkWord("s1b", 8'hFE, 3'd1, 1'b0);
    handshake();

    // Multi-beat, sign-extended
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("s2a.mid", 32'(chunk_count), 32'd1);
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b1);
    checkWord("s2a", 8'h1B, 3'd3, 1'b0);
    handshake();
    applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b1, 1'b1);
    checkWord("s2b", 8'hF1, 3'd3, 1'b0);
    handshake();

    // Auto-close at MAX_CHUNKS, with and without in_last
    applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkWord("s3a", 8'hE4, 3'd4, 1'b1);
    handshake();
    checkOutput("s3a.ovfclr", 32'(overflow), 32'd0);
    applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b1);
    checkWord("s3b", 8'hE4, 3'd4, 1'b0);
    handshake();

    // Backpressure: pending beat must wait through HOLD and the handshake bubble
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkWord("s4", 8'h01, 3'd1, 1'b0);
    in_valid = 1'b1; entrada = 2'b10; in_last = 1'b1; sign_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checkOutput("s4.ready", 32'(in_ready), 32'd0);
      checkOutput("s4.hold",  32'(saida), 32'h01);
      checkOutput("s4.cnt",   32'(chunk_count), 32'd1);
    end
    handshake();
    checkOutput("s4.bubble.valid", 32'(out_valid), 32'd0);
    checkOutput("s4.bubble.cnt",   32'(chunk_count), 32'd0);
    checkOutput("s4.bubble.ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    checkWord("s4b", 8'h02, 3'd1, 1'b0);
    handshake();

    // clear aborts a partial word, then clear beats out_ready in HOLD
    applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    checkOutput("s5.clr.cnt", 32'(chunk_count), 32'd0);
    applyStimulus(2'b01, 1'b1, 1'b1);
    checkWord("s5", 8'h01, 3'd1, 1'b0);
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0; out_ready = 1'b0;
    checkOutput("s5.clr.valid", 32'(out_valid), 32'd0);
    checkOutput("s5.clr.saida", 32'(saida), 32'h01);
    checkOutput("s5.clr.ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-ACCUM and mid-HOLD
    applyStimulus(2'b10, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("s6a.cnt",   32'(chunk_count), 32'd0);
    checkOutput("s6a.saida", 32'(saida), 32'd0);
    checkOutput("s6a.ready", 32'(in_ready), 32'd1);
    #2 reset = 1'b0;
    applyStimulus(2'b11, 1'b1, 1'b1);
    checkWord("s6b.pre", 8'hFF, 3'd1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("s6b.valid", 32'(out_valid), 32'd0);
    checkOutput("s6b.saida", 32'(saida), 32'd0);
    checkOutput("s6b.cnt",   32'(chunk_count), 32'd0);
    checkOutput("s6b.ovf",   32'(overflow), 32'd0);
    #2 reset = 1'b0;
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkWord("s6c", 8'h03, 3'd1, 1'b0);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
